// File: rtl/seq_mult.sv
// Iterative radix-2 shift-add multiplier, signed or unsigned, one operation in flight.
// Latency: out_valid rises WIDTH+1 edges after the accepting edge; back-to-back accepts are WIDTH+3 edges apart.
// Backpressure: in_ready drops for the whole operation; the product is held in DONE until out_ready.
module seq_mult #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               signed_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
  localparam logic [WIDTH-1:0] ONE_W    = WIDTH'(1);
  localparam logic [PW-1:0]    ONE_P    = PW'(1);

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [PW-1:0]    mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic             neg_q, neg_d;
  logic [PW-1:0]    p_q, p_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  // Next-state logic: load magnitudes in IDLE, shift-add in RUN, apply the sign in FIX, hold in DONE.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    acc_d       = acc_q;
    neg_d       = neg_q;
    p_d         = p_q;
    // Magnitude of the most negative value is 2^(WIDTH-1), which still fits in WIDTH unsigned bits.
    a_mag       = (signed_mode && a[WIDTH-1]) ? (~a + ONE_W) : a;
    b_mag       = (signed_mode && b[WIDTH-1]) ? (~b + ONE_W) : b;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          mcand_d  = {{WIDTH{1'b0}}, a_mag};
          mplier_d = b_mag;
          acc_d    = '0;
          cnt_d    = '0;
          neg_d    = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        if (mplier_q[0]) begin
          acc_d = acc_q + mcand_q;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        p_d     = neg_q ? (~acc_q + ONE_P) : acc_q;
        state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Handshake flags are registered copies of the state being entered.
    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_DONE);
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      neg_q       <= 1'b0;
      p_q         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      neg_q       <= neg_d;
      p_q         <= p_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign p         = p_q;

endmodule

// File: tb/tb_seq_mult.sv
// Directed bench for seq_mult: a WIDTH=16 and a WIDTH=8 instance on one clock.
// Inputs are driven 1 time unit after the rising edge and outputs sampled there too.
// Each scenario task makes its own comparisons against hand-computed values.
module tb_seq_mult;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        iv16, ir16, sm16, ov16, or16;
  logic [15:0] a16, b16;
  logic [31:0] p16;
  logic        iv8, ir8, sm8, ov8, or8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  seq_mult #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
    .signed_mode(sm16), .out_valid(ov16), .out_ready(or16), .p(p16)
  );

  seq_mult #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .signed_mode(sm8), .out_valid(ov8), .out_ready(or8), .p(p8)
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Present one operation, wait (bounded) for out_valid; reports edges after accept and any in_ready=1 seen.
  task automatic run16(input logic [15:0] ai, input logic [15:0] bi, input logic mi,
                       output logic [31:0] prod, output int lat, output bit ir_seen);
    ir_seen = 1'b0;
    a16 = ai; b16 = bi; sm16 = mi; iv16 = 1'b1;
    step();
    iv16 = 1'b0;
    lat = 0;
    while (lat < 40) begin
      if (ir16) ir_seen = 1'b1;
      step();
      lat++;
      if (ov16) break;
    end
    if (ir16) ir_seen = 1'b1;
    prod = p16;
  endtask

  task automatic finish16();
    or16 = 1'b1;
    step();
    or16 = 1'b0;
  endtask

  task automatic run8(input logic [7:0] ai, input logic [7:0] bi, input logic mi,
                      output logic [15:0] prod, output int lat);
    a8 = ai; b8 = bi; sm8 = mi; iv8 = 1'b1;
    step();
    iv8 = 1'b0;
    lat = 0;
    while (lat < 40) begin
      step();
      lat++;
      if (ov8) break;
    end
    prod = p8;
  endtask

  task automatic finish8();
    or8 = 1'b1;
    step();
    or8 = 1'b0;
  endtask

  function automatic logic [31:0] ref16(input logic [15:0] x, input logic [15:0] y, input logic m);
    longint sx, sy, r;
    if (m) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
    end else begin
      sx = longint'(x);
      sy = longint'(y);
    end
    r = sx * sy;
    return r[31:0];
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    iv16 = 0; a16 = '0; b16 = '0; sm16 = 0; or16 = 0;
    iv8 = 0; a8 = '0; b8 = '0; sm8 = 0; or8 = 0;
    step();
    step();
    checks++; if (ir16 !== 1'b1) begin failures++; $display("FAIL reset_in_ready16 got=%b exp=1", ir16); end
    checks++; if (ov16 !== 1'b0) begin failures++; $display("FAIL reset_out_valid16 got=%b exp=0", ov16); end
    checks++; if (p16 !== 32'h0) begin failures++; $display("FAIL reset_p16 got=%h exp=00000000", p16); end
    checks++; if (ir8 !== 1'b1) begin failures++; $display("FAIL reset_in_ready8 got=%b exp=1", ir8); end
    checks++; if (ov8 !== 1'b0) begin failures++; $display("FAIL reset_out_valid8 got=%b exp=0", ov8); end
    checks++; if (p8 !== 16'h0) begin failures++; $display("FAIL reset_p8 got=%h exp=0000", p8); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_unsigned_max();
    logic [31:0] prod;
    int lat;
    bit irs;
    run16(16'hFFFF, 16'hFFFF, 1'b0, prod, lat, irs);
    checks++; if (prod !== 32'hFFFE0001) begin failures++; $display("FAIL umax_product got=%h exp=fffe0001", prod); end
    checks++; if (lat !== 17) begin failures++; $display("FAIL umax_latency got=%0d exp=17", lat); end
    checks++; if (irs !== 1'b0) begin failures++; $display("FAIL umax_in_ready_busy got=%b exp=0", irs); end
    finish16();
    checks++; if (ov16 !== 1'b0) begin failures++; $display("FAIL umax_out_valid_after got=%b exp=0", ov16); end
    checks++; if (ir16 !== 1'b1) begin failures++; $display("FAIL umax_in_ready_after got=%b exp=1", ir16); end
    step();
    checks++; if (p16 !== 32'hFFFE0001) begin failures++; $display("FAIL umax_p_retained got=%h exp=fffe0001", p16); end
  endtask

  task automatic test_signed();
    logic [15:0] ta [4] = '{16'h8000, 16'hFFFF, 16'hFFFF, 16'h0000};
    logic [15:0] tb [4] = '{16'h8000, 16'h0001, 16'h0001, 16'hABCD};
    logic        tm [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    logic [31:0] te [4] = '{32'h40000000, 32'hFFFFFFFF, 32'h0000FFFF, 32'h00000000};
    logic [31:0] prod;
    int lat;
    bit irs;
    for (int i = 0; i < 4; i++) begin
      run16(ta[i], tb[i], tm[i], prod, lat, irs);
      checks++;
      if (prod !== te[i]) begin
        failures++;
        $display("FAIL signed_vec%0d a=%h b=%h mode=%b got=%h exp=%h", i, ta[i], tb[i], tm[i], prod, te[i]);
      end
      finish16();
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] prod;
    int lat;
    bit irs;
    run16(16'h0003, 16'h0005, 1'b0, prod, lat, irs);
    checks++; if (prod !== 32'h0000000F) begin failures++; $display("FAIL bp_product got=%h exp=0000000f", prod); end
    for (int i = 0; i < 5; i++) begin
      or16 = 1'b0;
      iv16 = ~iv16;
      a16  = 16'hA5A5 ^ 16'(i);
      b16  = 16'h5A5A + 16'(i);
      sm16 = ~sm16;
      step();
      checks++; if (p16 !== 32'h0000000F) begin failures++; $display("FAIL bp_p_hold%0d got=%h exp=0000000f", i, p16); end
      checks++; if (ov16 !== 1'b1) begin failures++; $display("FAIL bp_valid_hold%0d got=%b exp=1", i, ov16); end
      checks++; if (ir16 !== 1'b0) begin failures++; $display("FAIL bp_ready_low%0d got=%b exp=0", i, ir16); end
    end
    // in_valid high on the release edge must not start a new operation.
    iv16 = 1'b1;
    or16 = 1'b1;
    step();
    iv16 = 1'b0;
    or16 = 1'b0;
    checks++; if (ov16 !== 1'b0) begin failures++; $display("FAIL bp_release_valid got=%b exp=0", ov16); end
    checks++; if (ir16 !== 1'b1) begin failures++; $display("FAIL bp_release_ready got=%b exp=1", ir16); end
  endtask

  task automatic test_reset_mid_run();
    logic [31:0] prod;
    int lat;
    bit irs;
    a16 = 16'hFFFF; b16 = 16'hFFFF; sm16 = 1'b0; iv16 = 1'b1;
    step();
    iv16 = 1'b0;
    for (int i = 0; i < 8; i++) step();
    rst_n = 1'b0;
    step();
    checks++; if (ov16 !== 1'b0) begin failures++; $display("FAIL midrst_out_valid got=%b exp=0", ov16); end
    checks++; if (p16 !== 32'h0) begin failures++; $display("FAIL midrst_p got=%h exp=00000000", p16); end
    checks++; if (ir16 !== 1'b1) begin failures++; $display("FAIL midrst_in_ready got=%b exp=1", ir16); end
    rst_n = 1'b1;
    run16(16'h1234, 16'h0010, 1'b0, prod, lat, irs);
    checks++; if (prod !== 32'h00012340) begin failures++; $display("FAIL midrst_next_product got=%h exp=00012340", prod); end
    checks++; if (lat !== 17) begin failures++; $display("FAIL midrst_next_latency got=%0d exp=17", lat); end
    finish16();
  endtask

  task automatic test_width8();
    logic [15:0] prod;
    int lat;
    run8(8'h81, 8'hFF, 1'b0, prod, lat);
    checks++; if (prod !== 16'h807F) begin failures++; $display("FAIL w8_unsigned got=%h exp=807f", prod); end
    checks++; if (lat !== 9) begin failures++; $display("FAIL w8_unsigned_latency got=%0d exp=9", lat); end
    finish8();
    checks++; if (ir8 !== 1'b1) begin failures++; $display("FAIL w8_ready_after got=%b exp=1", ir8); end
    run8(8'h81, 8'hFF, 1'b1, prod, lat);
    checks++; if (prod !== 16'h007F) begin failures++; $display("FAIL w8_signed got=%h exp=007f", prod); end
    checks++; if (lat !== 9) begin failures++; $display("FAIL w8_signed_latency got=%0d exp=9", lat); end
    finish8();
  endtask

  task automatic test_back_to_back();
    logic [31:0] expq[$];
    logic [31:0] e;
    int last_acc = -1;
    int accepted = 0;
    int done     = 0;
    int guard    = 0;
    iv16 = 1'b1;
    or16 = 1'b1;
    a16  = 16'($urandom);
    b16  = 16'($urandom);
    sm16 = 1'($urandom_range(0, 1));
    while (done < 1000 && guard < 1000 * 19 + 200) begin
      if (ir16 && iv16) begin
        expq.push_back(ref16(a16, b16, sm16));
        if (last_acc >= 0) begin
          checks++;
          if (cyc - last_acc !== 19) begin
            failures++;
            $display("FAIL b2b_spacing op%0d got=%0d exp=19", accepted, cyc - last_acc);
          end
        end
        last_acc = cyc;
        accepted++;
      end
      step();
      guard++;
      if (accepted >= 1000) iv16 = 1'b0;
      a16  = 16'($urandom);
      b16  = 16'($urandom);
      sm16 = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) a16 = 16'h8000;
      if ($urandom_range(0, 15) == 0) b16 = 16'h8000;
      if ($urandom_range(0, 31) == 0) b16 = 16'h0000;
      if (ov16) begin
        checks++;
        if (expq.size() == 0) begin
          failures++;
          $display("FAIL b2b_unexpected_output got=%h exp=none", p16);
        end else begin
          e = expq.pop_front();
          if (p16 !== e) begin
            failures++;
            $display("FAIL b2b_product op%0d got=%h exp=%h", done, p16, e);
          end
        end
        done++;
      end
    end
    checks++;
    if (done !== 1000) begin failures++; $display("FAIL b2b_completed got=%0d exp=1000", done); end
    iv16 = 1'b0;
    or16 = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_unsigned_max();
    test_signed();
    test_backpressure();
    test_reset_mid_run();
    test_width8();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_mult.md
SEQ_MULT -- requirements
Module: seq_mult

Interface
REQ-001 Parameter: WIDTH, default 16, operand width in bits; legal range 4..32.
REQ-002 Port: clk  input  1  rising-edge clock; sole clock.
REQ-003 Port: rst_n  input  1  reset; synchronous, active-low.
REQ-004 Port: in_valid  input  1  operands and mode presented.
REQ-005 Port: in_ready  output  1  block can accept an operation.
REQ-006 Port: a  input  WIDTH  multiplicand.
REQ-007 Port: b  input  WIDTH  multiplier.
REQ-008 Port: signed_mode  input  1  1 = two's-complement operands, 0 = unsigned.
REQ-009 Port: out_valid  output  1  p holds a completed product.
REQ-010 Port: out_ready  input  1  consumer takes the product.
REQ-011 Port: p  output  2*WIDTH  product.

Function
REQ-012 Iterative radix-2 shift-add multiplier; one operation in flight at a time.
REQ-013 FSM states: IDLE, RUN, FIX, DONE.
REQ-014 IDLE: in_ready=1; on an edge with in_valid=1, latch a, b and signed_mode, then go to RUN with the bit counter at 0.
REQ-015 RUN: each edge processes one multiplier bit (add shifted multiplicand when the bit is 1), counter increments; after exactly WIDTH RUN edges, go to FIX.
REQ-016 Signed operands SHALL be converted to magnitudes at load; FIX applies the result sign (XOR of operand sign bits), writes p, sets out_valid=1 and goes to DONE.
REQ-017 Latency: out_valid rises on the (WIDTH+1)th rising edge after the accepting edge (17 for WIDTH=16).
REQ-018 DONE: out_valid=1 and p stable; on an edge with out_ready=1, out_valid=0 and go to IDLE; no new operation is accepted on that edge.
REQ-019 in_ready=0 in RUN, FIX and DONE; in_valid, a, b and signed_mode are ignored outside IDLE.
REQ-020 p changes only in FIX or on reset; p retains its last value after the output handshake.
REQ-021 Product is exact in 2*WIDTH bits for every input pair, including signed min*min (e.g. 0x8000*0x8000 -> 0x40000000) and any zero operand.
REQ-022 in_ready, out_valid and p SHALL be registered outputs.

Reset
REQ-023 On an edge with rst_n=0, from any state: state=IDLE, in_ready=1, out_valid=0, p=0, counter=0, operand registers=0.
REQ-024 Reset during RUN, FIX or DONE aborts the operation with no output handshake; the first edge with rst_n=1 and in_valid=1 starts a fresh operation.

Verification
REQ-025 WIDTH=16, unsigned: a=0xFFFF, b=0xFFFF -> p=0xFFFE0001, out_valid exactly 17 edges after accept, in_ready=0 throughout.
REQ-026 WIDTH=16, signed: 0x8000*0x8000 -> 0x40000000; 0xFFFF*0x0001 -> 0xFFFFFFFF; the same pair unsigned -> 0x0000FFFF; 0x0000*0xABCD -> 0x00000000.
REQ-027 Backpressure: hold out_ready=0 for 5 cycles in DONE while toggling in_valid/a/b -> p and out_valid stable, in_ready=0; out_ready=1 -> out_valid=0 and in_ready=1 on the next edge.
REQ-028 Reset mid-RUN (8 edges after accept) -> next edge out_valid=0, p=0, in_ready=1; a subsequent 0x1234*0x0010 unsigned -> 0x00012340.
REQ-029 WIDTH=8 instance: 0x81*0xFF unsigned -> 0x807F after 9 edges; signed -> 0x007F.
REQ-030 Back-to-back: in_valid held high with out_ready=1 -> accepts spaced WIDTH+3 edges apart, each product matching a reference model over 1000 random operand/mode triples.
